// File: rtl/fpnew_pkg.sv
// Slice of the FPU package: the format, rounding-mode and operation types
// and the width helpers used by the divsqrt issue queue.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned FP_FORMAT_BITS = $clog2(NUM_FP_FORMATS);

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32    = 'd0,
    FP64    = 'd1,
    FP16    = 'd2,
    FP8     = 'd3,
    FP16ALT = 'd4
  } fp_format_e;

  typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  localparam int unsigned OP_BITS = 4;

  typedef enum logic [OP_BITS-1:0] {
    FMADD, FNMSUB, ADD, MUL,
    DIV, SQRT,
    SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F,
    CPKAB, CPKCD
  } operation_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned max_fp_width(input fmt_logic_t cfg);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
      if (cfg[i] && (fp_width(fp_format_e'(i)) > res)) res = fp_width(fp_format_e'(i));
    end
    return res;
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_issue_queue.sv
// In-order operation queue in front of the iterative divsqrt unit. Holds full
// op contexts, optionally falls through when empty, and can be flushed.
module fpnew_divsqrt_issue_queue import fpnew_pkg::*; #(
  parameter fmt_logic_t  FpFmtConfig = '1,
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b0,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic,
  localparam int unsigned WIDTH       = max_fp_width(FpFmtConfig),
  localparam int unsigned NUM_FORMATS = NUM_FP_FORMATS
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [1:0][WIDTH-1:0]              operands_i,
  input  logic [NUM_FORMATS-1:0][1:0]        is_boxed_i,
  input  roundmode_e                         rnd_mode_i,
  input  operation_e                         op_i,
  input  fp_format_e                         dst_fmt_i,
  input  TagType                             tag_i,
  input  AuxType                             aux_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic                               flush_i,
  output logic [1:0][WIDTH-1:0]              operands_o,
  output logic [NUM_FORMATS-1:0][1:0]        is_boxed_o,
  output roundmode_e                         rnd_mode_o,
  output operation_e                         op_o,
  output fp_format_e                         dst_fmt_o,
  output TagType                             tag_o,
  output AuxType                             aux_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [$clog2(Depth+1)-1:0]         occupancy_o,
  output logic                               busy_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  typedef struct packed {
    logic [1:0][WIDTH-1:0]       operands;
    logic [NUM_FORMATS-1:0][1:0] is_boxed;
    roundmode_e                  rnd_mode;
    operation_e                  op;
    fp_format_e                  dst_fmt;
    TagType                      tag;
    AuxType                      aux;
  } entry_t;

  entry_t        in_entry, head_entry;
  entry_t        mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, fall_through, bypass, push, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign in_entry = '{operands: operands_i, is_boxed: is_boxed_i, rnd_mode: rnd_mode_i,
                      op: op_i, dst_fmt: dst_fmt_i, tag: tag_i, aux: aux_i};

  assign full  = (count_q == CW'(Depth));
  assign empty = (count_q == '0);

  // fall_through drives the outputs from the inputs; bypass means the op is also consumed
  assign fall_through = FallThrough & empty & in_valid_i & ~flush_i;
  assign bypass       = fall_through & out_ready_i;

  assign in_ready_o  = ~full & ~flush_i;
  assign out_valid_o = (~empty & ~flush_i) | fall_through;

  assign push = in_valid_i & in_ready_o & ~bypass;
  assign pop  = out_valid_o & out_ready_i & ~bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is only ever read behind a valid count, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign head_entry = fall_through ? in_entry : mem_q[rd_ptr_q];

  assign operands_o  = head_entry.operands;
  assign is_boxed_o  = head_entry.is_boxed;
  assign rnd_mode_o  = head_entry.rnd_mode;
  assign op_o        = head_entry.op;
  assign dst_fmt_o   = head_entry.dst_fmt;
  assign tag_o       = head_entry.tag;
  assign aux_o       = head_entry.aux;
  assign occupancy_o = count_q;
  assign busy_o      = in_valid_i | ~empty;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
  a_count_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CW'(Depth));

endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
// Scoreboard bench: instance A (Depth 2, registered) and instance B
// (Depth 2, fall-through) share stimulus; sel picks the active one.
module tb_fpnew_divsqrt_issue_queue;
  import fpnew_pkg::*;

  typedef struct packed {
    logic [7:0]  tag;
    logic [3:0]  aux;
    operation_e  op;
    roundmode_e  rnd;
    fp_format_e  fmt;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, sel = 1'b0;
  exp_t cur = '0;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  logic [1:0][31:0] opnds_in;
  logic [4:0][1:0]  boxed_in;
  assign opnds_in = {cur.b, cur.a};
  assign boxed_in = '1;

  logic             a_in_ready, a_out_valid, a_busy, b_in_ready, b_out_valid, b_busy;
  logic [1:0]       a_occ, b_occ;
  logic [1:0][31:0] a_opnds, b_opnds;
  logic [4:0][1:0]  a_boxed, b_boxed;
  roundmode_e       a_rnd, b_rnd;
  operation_e       a_op, b_op;
  fp_format_e       a_fmt, b_fmt;
  logic [7:0]       a_tag, b_tag;
  logic [3:0]       a_aux, b_aux;

  fpnew_divsqrt_issue_queue #(
    .FpFmtConfig(5'b10000), .Depth(2), .FallThrough(1'b0),
    .TagType(logic [7:0]), .AuxType(logic [3:0])
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(opnds_in), .is_boxed_i(boxed_in),
    .rnd_mode_i(cur.rnd), .op_i(cur.op), .dst_fmt_i(cur.fmt), .tag_i(cur.tag), .aux_i(cur.aux),
    .in_valid_i(in_valid & ~sel), .in_ready_o(a_in_ready), .flush_i(flush),
    .operands_o(a_opnds), .is_boxed_o(a_boxed), .rnd_mode_o(a_rnd), .op_o(a_op),
    .dst_fmt_o(a_fmt), .tag_o(a_tag), .aux_o(a_aux), .out_valid_o(a_out_valid),
    .out_ready_i(out_ready & ~sel), .occupancy_o(a_occ), .busy_o(a_busy)
  );

  fpnew_divsqrt_issue_queue #(
    .FpFmtConfig(5'b10000), .Depth(2), .FallThrough(1'b1),
    .TagType(logic [7:0]), .AuxType(logic [3:0])
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(opnds_in), .is_boxed_i(boxed_in),
    .rnd_mode_i(cur.rnd), .op_i(cur.op), .dst_fmt_i(cur.fmt), .tag_i(cur.tag), .aux_i(cur.aux),
    .in_valid_i(in_valid & sel), .in_ready_o(b_in_ready), .flush_i(flush),
    .operands_o(b_opnds), .is_boxed_o(b_boxed), .rnd_mode_o(b_rnd), .op_o(b_op),
    .dst_fmt_o(b_fmt), .tag_o(b_tag), .aux_o(b_aux), .out_valid_o(b_out_valid),
    .out_ready_i(out_ready & sel), .occupancy_o(b_occ), .busy_o(b_busy)
  );

  exp_t got;
  logic mon_valid;
  assign got = sel ? {b_tag, b_aux, b_op, b_rnd, b_fmt, b_opnds[0], b_opnds[1]}
                   : {a_tag, a_aux, a_op, a_rnd, a_fmt, a_opnds[0], a_opnds[1]};
  assign mon_valid = sel ? b_out_valid : a_out_valid;

  // Monitor: every accepted head entry must match the oldest expected op
  always @(negedge clk) begin
    if (rst_n && mon_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got tag=%0h op=%0d a=%h, want no output", got.tag, got.op, got.a);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL sb_entry: got tag=%0h aux=%0h op=%0d rnd=%0d a=%h b=%h, want tag=%0h aux=%0h op=%0d rnd=%0d a=%h b=%h",
                   got.tag, got.aux, got.op, got.rnd, got.a, got.b, e.tag, e.aux, e.op, e.rnd, e.a, e.b);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] t, input operation_e o, input logic [31:0] a);
    exp_t e;
    e.tag = t;
    e.aux = t[3:0] ^ 4'hA;
    e.op  = o;
    e.rnd = roundmode_e'({1'b0, t[1:0]});
    e.fmt = FP32;
    e.a   = a;
    e.b   = ~a;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic send(input exp_t e);
    cur = e;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    sample();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_occ",       32'(a_occ),       32'd0);
    check("rst_busy",      32'(a_busy),      32'd0);
    check("rst_ft_valid",  32'(b_out_valid), 32'd0);
    tick();
    rst_n = 1'b1;

    // back-to-back DIV ops, consumer always ready
    out_ready = 1'b1;
    tick(); send(mk(8'd1, DIV, 32'h3F800000)); sample();
    check("t1_valid_c0", 32'(a_out_valid), 32'd0);
    check("t1_ready_c0", 32'(a_in_ready),  32'd1);
    tick(); send(mk(8'd2, DIV, 32'h40000000)); sample();
    check("t1_valid_c1", 32'(a_out_valid), 32'd1);
    check("t1_occ_c1",   32'(a_occ),       32'd1);
    tick(); send(mk(8'd3, DIV, 32'h40400000)); sample();
    check("t1_occ_c2",   32'(a_occ),       32'd1);
    tick(); idle(); sample();
    check("t1_valid_c3", 32'(a_out_valid), 32'd1);
    check("t1_busy_c3",  32'(a_busy),      32'd1);
    tick(); sample();
    check("t1_valid_c4", 32'(a_out_valid), 32'd0);
    check("t1_occ_c4",   32'(a_occ),       32'd0);

    // backpressure: fill, hold, then drain
    out_ready = 1'b0;
    tick(); send(mk(8'd4, DIV, 32'h40800000)); sample();
    check("t2_ready_0", 32'(a_in_ready), 32'd1);
    tick(); send(mk(8'd5, SQRT, 32'h41000000)); sample();
    check("t2_ready_1", 32'(a_in_ready), 32'd1);
    check("t2_occ_1",   32'(a_occ),      32'd1);
    tick(); send(mk(8'd6, DIV, 32'h41800000)); sample();
    check("t2_ready_full", 32'(a_in_ready), 32'd0);
    check("t2_occ_full",   32'(a_occ),      32'd2);
    check("t2_head",       32'(a_tag),      32'h4);
    tick(); sample();
    check("t2_head_hold",  32'(a_tag),      32'h4);
    check("t2_hold_valid", 32'(a_out_valid), 32'd1);
    tick(); out_ready = 1'b1; sample();
    check("t2_no_comb_ready", 32'(a_in_ready), 32'd0);
    tick(); sample();
    check("t2_third_accept", 32'(a_in_ready), 32'd1);
    tick(); idle(); sample();
    check("t2_occ_last", 32'(a_occ), 32'd1);
    tick(); sample();
    check("t2_occ_empty", 32'(a_occ), 32'd0);

    // simultaneous push and pop with one entry queued
    out_ready = 1'b0;
    tick(); send(mk(8'd8, DIV, 32'hC0000000)); sample();
    tick(); idle(); sample();
    check("t3_occ_pre", 32'(a_occ), 32'd1);
    tick(); out_ready = 1'b1; send(mk(8'd9, SQRT, 32'h3E800000)); sample();
    tick(); idle(); sample();
    check("t3_occ_same", 32'(a_occ), 32'd1);
    tick(); sample();
    check("t3_occ_post", 32'(a_occ), 32'd0);

    // flush with two entries
    out_ready = 1'b0;
    tick(); send(mk(8'd10, DIV, 32'h3F000000)); sample();
    tick(); send(mk(8'd11, DIV, 32'h3F400000)); sample();
    tick(); idle(); flush = 1'b1; exp_q.delete(); sample();
    check("t4_flush_valid", 32'(a_out_valid), 32'd0);
    check("t4_flush_ready", 32'(a_in_ready),  32'd0);
    tick(); flush = 1'b0; sample();
    check("t4_occ_after", 32'(a_occ),       32'd0);
    check("t4_valid_after", 32'(a_out_valid), 32'd0);
    tick(); out_ready = 1'b1; send(mk(8'd7, DIV, 32'h42000000)); sample();
    tick(); idle(); sample();
    check("t4_first_tag", 32'(a_tag), 32'h7);
    tick(); sample();

    // asynchronous reset with one entry queued
    out_ready = 1'b0;
    tick(); send(mk(8'd12, DIV, 32'h42800000)); sample();
    tick(); idle(); sample();
    check("t5_pre_occ",   32'(a_occ),       32'd1);
    check("t5_pre_valid", 32'(a_out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(a_out_valid), 32'd0);
    check("t5_rst_occ",   32'(a_occ),       32'd0);
    exp_q.delete();
    tick(); rst_n = 1'b1;
    tick(); out_ready = 1'b1; send(mk(8'd13, SQRT, 32'h43000000)); sample();
    tick(); idle(); sample();
    tick(); sample();
    check("t5_resume_occ", 32'(a_occ), 32'd0);

    // fall-through instance
    tick(); sel = 1'b1; send(mk(8'd20, SQRT, 32'h40800000)); sample();
    check("t6_ft_valid", 32'(b_out_valid), 32'd1);
    check("t6_ft_occ",   32'(b_occ),       32'd0);
    check("t6_ft_opnd",  b_opnds[0],       32'h40800000);
    tick(); idle(); sample();
    check("t6_ft_occ_next",   32'(b_occ),       32'd0);
    check("t6_ft_valid_next", 32'(b_out_valid), 32'd0);
    tick(); out_ready = 1'b0; send(mk(8'd21, SQRT, 32'h41100000)); sample();
    check("t6_ft_stall_valid", 32'(b_out_valid), 32'd1);
    check("t6_ft_stall_tag",   32'(b_tag),       32'h15);
    tick(); idle(); sample();
    check("t6_ft_stored_occ", 32'(b_occ), 32'd1);
    check("t6_ft_stored_tag", 32'(b_tag), 32'h15);
    tick(); out_ready = 1'b1; sample();
    tick(); sample();
    check("t6_ft_drained", 32'(b_occ), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
